// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared decode field positions, encodings and helpers
// Purpose: instruction field layout, register/ALU constants shared by decode and execute.
// Ports: none (package).
package decode_stage_pkg;

  localparam int NREG_DEF = 32;
  localparam int DW_DEF   = 32;

  // Instruction field bit positions
  localparam int AOP_MSB     = 31;
  localparam int AOP_LSB     = 29;
  localparam int DATASRC_BIT = 28;
  localparam int RS_MSB      = 25;
  localparam int RS_LSB      = 21;
  localparam int RT_MSB      = 20;
  localparam int RT_LSB      = 16;
  localparam int RD_MSB      = 15;
  localparam int RD_LSB      = 11;
  localparam int IMM_MSB     = 15;
  localparam int IMM_LSB     = 0;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam logic       DATASRC_IMM = 1'b1;

  // ALU operation encodings, shared with the execute stage
  localparam logic [2:0] AOP_ADD = 3'd0;
  localparam logic [2:0] AOP_SUB = 3'd1;
  localparam logic [2:0] AOP_AND = 3'd2;
  localparam logic [2:0] AOP_OR  = 3'd3;
  localparam logic [2:0] AOP_XOR = 3'd4;
  localparam logic [2:0] AOP_SLT = 3'd5;
  localparam logic [2:0] AOP_SLL = 3'd6;
  localparam logic [2:0] AOP_SRL = 3'd7;

  // Immediate-form instructions write rt, register-form write rd.
  function automatic logic [4:0] dest_of(input logic datasrc, input logic [4:0] rt,
                                         input logic [4:0] rd);
    return (datasrc == DATASRC_IMM) ? rt : rd;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-to-decode instruction handshake
// Purpose: carries the fetched instruction and its valid/ready handshake.
// Signals: instr (32), instr_valid (fetch->decode), instr_ready (decode->fetch).
// Modports: master = fetch side, slave = decode side.
interface decode_stage_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/decode_stage_regfile_32x32.sv
// rtl/decode_stage_regfile_32x32.sv - 2-read/1-write register file with write-through bypass
// Purpose: architectural registers; r0 hardwired to zero, async active-low clear.
// Ports: clk, rst (async, active-low); we/wsel/wdata write port;
//        ra1/ra2 read indices; rd1/rd2 combinational read data.
module regfile_32x32
  import decode_stage_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [4:0]    wsel,
  input  logic [DW-1:0] wdata,
  input  logic [4:0]    ra1,
  input  logic [4:0]    ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2
);

  // r0 has no storage; it is decoded as constant zero on reads.
  logic [DW-1:0] mem [1:NREG-1];
  logic          wr_en;

  assign wr_en = we && (wsel != REG_ZERO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREG; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wsel] <= wdata;
    end
  end

  // Bypass lets a consumer read the value writeback is committing this cycle.
  assign rd1 = (ra1 == REG_ZERO) ? '0 : (wr_en && wsel == ra1) ? wdata : mem[ra1];
  assign rd2 = (ra2 == REG_ZERO) ? '0 : (wr_en && wsel == ra2) ? wdata : mem[ra2];

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode stage: field decode, register read, RAW stall
// Purpose: decodes the fetched instruction, reads operands and registers the
//          execute bundle; inserts a one-cycle bubble on RAW against execute.
// Ports: clk, rst (async, active-low); fetch (decode_stage_if.slave);
//        we/wsel/wdata writeback port; rdata1, rdata2, imm, datasrc, aop, ws,
//        out_valid registered bundle to execute.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  fetch,
  input  logic           we,
  input  logic [4:0]     wsel,
  input  logic [DW-1:0]  wdata,
  output logic [DW-1:0]  rdata1,
  output logic [DW-1:0]  rdata2,
  output logic [15:0]    imm,
  output logic           datasrc,
  output logic [2:0]     aop,
  output logic [4:0]     ws,
  output logic           out_valid
);

  logic [2:0]    d_aop;
  logic          d_datasrc;
  logic [4:0]    d_rs, d_rt, d_rd, d_dest;
  logic [15:0]   d_imm;
  logic [DW-1:0] rf_rd1, rf_rd2;
  logic [4:0]    pend_ws;
  logic          pending_valid;
  logic          hazard, accept;
  logic          unused_instr_bits;

  assign d_aop     = fetch.instr[AOP_MSB:AOP_LSB];
  assign d_datasrc = fetch.instr[DATASRC_BIT];
  assign d_rs      = fetch.instr[RS_MSB:RS_LSB];
  assign d_rt      = fetch.instr[RT_MSB:RT_LSB];
  assign d_rd      = fetch.instr[RD_MSB:RD_LSB];
  assign d_imm     = fetch.instr[IMM_MSB:IMM_LSB];
  assign d_dest    = dest_of(d_datasrc, d_rt, d_rd);
  assign unused_instr_bits = ^fetch.instr[27:26];

  regfile_32x32 #(.NREG(NREG), .DW(DW)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .wsel  (wsel),
    .wdata (wdata),
    .ra1   (d_rs),
    .ra2   (d_rt),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2)
  );

  // The instruction accepted last cycle is in execute and has not written
  // back yet. rt only matters when the register form actually reads it.
  assign hazard = fetch.instr_valid && pending_valid && (pend_ws != REG_ZERO) &&
                  ((d_rs == pend_ws) || (d_datasrc != DATASRC_IMM && d_rt == pend_ws));
  assign accept = fetch.instr_valid && !hazard;
  assign fetch.instr_ready = !hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata1        <= '0;
      rdata2        <= '0;
      imm           <= '0;
      datasrc       <= 1'b0;
      aop           <= '0;
      ws            <= '0;
      out_valid     <= 1'b0;
      pend_ws       <= '0;
      pending_valid <= 1'b0;
    end else if (accept) begin
      rdata1        <= rf_rd1;
      rdata2        <= rf_rd2;
      imm           <= d_imm;
      datasrc       <= d_datasrc;
      aop           <= d_aop;
      ws            <= d_dest;
      out_valid     <= 1'b1;
      pend_ws       <= d_dest;
      pending_valid <= 1'b1;
    end else begin
      // Bubble: dropping pending_valid bounds every stall to one cycle,
      // since the producer reaches writeback and the bypass covers it.
      rdata1        <= '0;
      rdata2        <= '0;
      imm           <= '0;
      datasrc       <= 1'b0;
      aop           <= '0;
      ws            <= '0;
      out_valid     <= 1'b0;
      pending_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  wsel;
  logic [31:0] wdata;
  logic [31:0] rdata1, rdata2;
  logic [15:0] imm;
  logic        datasrc;
  logic [2:0]  aop;
  logic [4:0]  ws;
  logic        out_valid;

  decode_stage_if fetch_bus ();

  decode_stage dut (
    .clk       (clk),
    .rst       (rst),
    .fetch     (fetch_bus),
    .we        (we),
    .wsel      (wsel),
    .wdata     (wdata),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .imm       (imm),
    .datasrc   (datasrc),
    .aop       (aop),
    .ws        (ws),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: architectural register array plus "what is in execute".
  logic [31:0] m_reg [32];
  logic        m_busy;
  logic [4:0]  m_busy_reg;
  logic [31:0] e_r1, e_r2;
  logic [15:0] e_imm;
  logic        e_ds, e_ov;
  logic [2:0]  e_aop;
  logic [4:0]  e_ws;
  logic        obs_ready;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_busy = 1'b0; m_busy_reg = 5'd0;
    e_r1 = 0; e_r2 = 0; e_imm = 0; e_ds = 0; e_ov = 0; e_aop = 0; e_ws = 0;
  endtask

  function automatic logic [31:0] mk(input int a, input int ds, input int rs, input int rt,
                                     input int rd, input int low11);
    logic [31:0] w;
    w = 32'h0;
    w[31:29] = 3'(a); w[28] = 1'(ds); w[25:21] = 5'(rs); w[20:16] = 5'(rt);
    w[15:11] = 5'(rd); w[10:0] = 11'(low11);
    return w;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx, input logic w,
                                         input logic [4:0] s, input logic [31:0] d);
    if (idx == 0) return 32'h0;
    if (w && s == idx) return d;
    return m_reg[idx];
  endfunction

  function automatic logic m_stall(input logic [31:0] i, input logic v);
    logic [4:0] rs, rt;
    rs = i[25:21]; rt = i[20:16];
    if (!v || !m_busy || m_busy_reg == 0) return 1'b0;
    return (rs == m_busy_reg) || (!i[28] && rt == m_busy_reg);
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
    chk({tag, ".rdata1"}, rdata1, e_r1);
    chk({tag, ".rdata2"}, rdata2, e_r2);
    chk({tag, ".imm"}, 32'(imm), 32'(e_imm));
    chk({tag, ".datasrc"}, 32'(datasrc), 32'(e_ds));
    chk({tag, ".aop"}, 32'(aop), 32'(e_aop));
    chk({tag, ".ws"}, 32'(ws), 32'(e_ws));
  endtask

  // One cycle: drive after negedge, check ready, clock, check bundle.
  task automatic step(input string tag, input logic [31:0] i, input logic v, input logic w,
                      input logic [4:0] s, input logic [31:0] d);
    logic stall;
    fetch_bus.instr = i; fetch_bus.instr_valid = v;
    we = w; wsel = s; wdata = d;
    #1;
    stall = m_stall(i, v);
    obs_ready = fetch_bus.instr_ready;
    chk({tag, ".instr_ready"}, 32'(obs_ready), 32'(!stall));
    @(posedge clk);
    if (v && !stall) begin
      e_r1 = m_read(i[25:21], w, s, d);
      e_r2 = m_read(i[20:16], w, s, d);
      e_imm = i[15:0]; e_ds = i[28]; e_aop = i[31:29]; e_ov = 1'b1;
      e_ws = i[28] ? i[20:16] : i[15:11];
      m_busy = 1'b1; m_busy_reg = e_ws;
    end else begin
      e_r1 = 0; e_r2 = 0; e_imm = 0; e_ds = 0; e_aop = 0; e_ws = 0; e_ov = 0;
      m_busy = 1'b0;
    end
    if (w && s != 0) m_reg[s] = d;
    #1;
    check_outs(tag);
    @(negedge clk);
  endtask

  logic [31:0] cur_i;
  logic        cur_v;

  initial begin
    rst = 1'b0; we = 0; wsel = 0; wdata = 0;
    fetch_bus.instr = 32'h0; fetch_bus.instr_valid = 1'b0;
    model_reset();
    obs_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_outs("reset");
    chk("reset.instr_ready", 32'(fetch_bus.instr_ready), 32'h1);
    rst = 1'b1;

    // Write r5, then register-form read of r5 and r0
    step("wr5", 32'h0, 1'b0, 1'b1, 5'd5, 32'h0000_00AA);
    step("rdr5", mk(1, 0, 5, 0, 6, 0), 1'b1, 1'b0, 5'd0, 32'h0);
    chk("rdr5.rdata1_abs", rdata1, 32'hAA);
    chk("rdr5.ws_abs", 32'(ws), 32'd6);

    // Immediate form; rt equals nothing pending, ds=1
    step("immf", 32'h5CA7_1234 & 32'hF3FF_FFFF | 32'h40A7_1234, 1'b1, 1'b0, 5'd0, 32'h0);
    chk("immf.imm_abs", 32'(imm), 32'h1234);
    chk("immf.ws_abs", 32'(ws), 32'd7);
    chk("immf.aop_abs", 32'(aop), 32'd2);

    // Back-to-back RAW on r7: one bubble, then bypass from writeback
    step("raw0", mk(0, 0, 1, 2, 7, 0), 1'b1, 1'b0, 5'd0, 32'h0);
    step("raw1", mk(3, 0, 7, 0, 8, 0), 1'b1, 1'b0, 5'd0, 32'h0);
    chk("raw1.ready_abs", 32'(obs_ready), 32'h0);
    chk("raw1.out_valid_abs", 32'(out_valid), 32'h0);
    step("raw2", mk(3, 0, 7, 0, 8, 0), 1'b1, 1'b1, 5'd7, 32'h55);
    chk("raw2.rdata1_abs", rdata1, 32'h55);

    // No false hazards
    step("nf_a", mk(0, 1, 1, 9, 0, 0), 1'b1, 1'b0, 5'd0, 32'h0);
    step("nf_b", mk(0, 1, 1, 9, 0, 0), 1'b1, 1'b0, 5'd0, 32'h0);
    chk("nf_imm_rt.ready_abs", 32'(obs_ready), 32'h1);
    step("nf_c", mk(0, 0, 1, 2, 0, 0), 1'b1, 1'b0, 5'd0, 32'h0);
    step("nf_d", mk(0, 0, 0, 0, 3, 0), 1'b1, 1'b0, 5'd0, 32'h0);
    chk("nf_r0.ready_abs", 32'(obs_ready), 32'h1);
    step("nf_e", mk(0, 0, 1, 2, 10, 0), 1'b1, 1'b0, 5'd0, 32'h0);
    step("nf_f", 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    step("nf_g", mk(0, 0, 10, 10, 11, 0), 1'b1, 1'b0, 5'd0, 32'h0);
    chk("nf_bubble.ready_abs", 32'(obs_ready), 32'h1);

    // r0 writes are dropped and never bypassed
    step("r0w", 32'h0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    step("r0r", mk(0, 0, 0, 0, 12, 0), 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    chk("r0r.rdata1_abs", rdata1, 32'h0);

    // Randomised traffic over a few registers to provoke hazards and bypasses
    cur_i = 32'h0; cur_v = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic        w;
      logic [4:0]  s;
      logic [31:0] d;
      if (obs_ready || !cur_v) begin
        cur_i = $urandom();
        cur_i[25:21] = 5'($urandom_range(0, 3));
        cur_i[20:16] = 5'($urandom_range(0, 3));
        cur_i[15:11] = 5'($urandom_range(0, 3));
        cur_v = ($urandom_range(0, 3) != 0);
      end
      w = ($urandom_range(0, 1) == 1);
      s = 5'($urandom_range(0, 4));
      d = $urandom();
      step("rnd", cur_i, cur_v, w, s, d);
    end

    // Asynchronous reset in the middle of a stall
    step("ar_w", 32'h0, 1'b0, 1'b1, 5'd5, 32'h0000_00AA);
    step("ar0", mk(1, 0, 1, 2, 13, 0), 1'b1, 1'b0, 5'd0, 32'h0);
    fetch_bus.instr = mk(1, 0, 13, 0, 14, 0); fetch_bus.instr_valid = 1'b1;
    we = 0; wsel = 0; wdata = 0;
    #2;
    chk("ar.stall_ready", 32'(fetch_bus.instr_ready), 32'h0);
    rst = 1'b0;
    #1;
    model_reset();
    check_outs("ar");
    chk("ar.instr_ready", 32'(fetch_bus.instr_ready), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    step("ar_rd5", mk(0, 0, 5, 5, 15, 0), 1'b1, 1'b0, 5'd0, 32'h0);
    chk("ar_rd5.rdata1_abs", rdata1, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
